count32_timer_ctrl: RTL and testbench

- Controller and sequencer for a 32-bit up-counter datapath, with the counter embedded in the block.
- Adds start/stop/clear sequencing, a programmable prescaler, a terminal-count limit, and one-shot or periodic operation.
- Sits between the control/register logic, which drives the commands, and downstream logic that consumes the `tick` pulse or the `done` status.

---
 rtl/count32_timer_ctrl.sv | 146 ++++++++++++++
 tb/tb_count32_timer_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/count32_timer_ctrl.sv
// count32_timer_ctrl
//   Start/stop/clear sequencer around an embedded up-counter with a
//   programmable prescaler, terminal-count limit and one-shot/periodic modes.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       synchronous reset, active low
//   start_i      start from IDLE/DONE (relatches config) or resume from PAUSE
//   stop_i       pause the count
//   clear_i      abort to IDLE
//   mode_i       0 = one-shot, 1 = periodic (latched on start)
//   limit_i      terminal count value (latched on start)
//   prescale_i   clk cycles per count step minus 1 (latched on start)
//   count_o      current count, registered
//   tick_o       one-cycle pulse on the terminal step, registered
//   busy_o       high while running
//   done_o       sticky one-shot completion flag, registered
module count32_timer_ctrl #(
  parameter int WIDTH = 32,
  parameter int PW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic [PW-1:0]    prescale_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PC_ONE  = {{(PW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic launch, advance, step, terminal;

  // Start from IDLE/DONE; clear and stop both outrank start.
  assign launch = start_i && !stop_i && !clear_i &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  // A counting cycle happens in RUN, and also on the resume edge out of
  // PAUSE, so a pause costs exactly as many cycles as stop was held.
  assign advance = !clear_i && !stop_i &&
                   ((state_q == S_RUN) || ((state_q == S_PAUSE) && start_i));

  assign step     = advance && (pc_q == pre_q);
  assign terminal = step && (count_q == limit_q);

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pc_q    <= '0;
      limit_q <= '0;
      pre_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      limit_q <= limit_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (launch) state_d = S_RUN;
        S_RUN, S_PAUSE: begin
          if (stop_i)       state_d = S_PAUSE;
          else if (advance) state_d = (terminal && !mode_q) ? S_DONE : S_RUN;
        end
        default:          state_d = S_IDLE;
      endcase
    end
  end

  // Datapath / registered-output next values
  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    limit_d = limit_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    if (clear_i) begin
      count_d = '0;
      pc_d    = '0;
      done_d  = 1'b0;
    end else if (launch) begin
      mode_d  = mode_i;
      limit_d = limit_i;
      pre_d   = prescale_i;
      count_d = '0;
      pc_d    = '0;
      done_d  = 1'b0;
    end else if (advance) begin
      if (step) begin
        pc_d = '0;
        if (terminal) begin
          tick_d = 1'b1;
          // periodic wraps to 0; one-shot holds at the limit
          if (mode_q) count_d = '0;
          else        done_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        pc_d = pc_q + PC_ONE;
      end
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == S_RUN);

endmodule

// File: tb/tb_count32_timer_ctrl.sv
// Testbench for count32_timer_ctrl: directed stimulus pushes expected
// per-cycle snapshots and expected tick cycles into queues; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_count32_timer_ctrl;
  localparam int W  = 32;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic [W-1:0]  limit = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  count;
  logic          tick, busy, done;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic         tick;
  } exp_t;

  exp_t eq[$];
  int   tq[$];
  exp_t me;
  int   mt;

  count32_timer_ctrl #(.WIDTH(W), .PW(PW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .clear_i(clear), .mode_i(mode), .limit_i(limit), .prescale_i(prescale),
    .count_o(count), .tick_o(tick), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;  // cyc = number of rising edges seen

  // Monitor: snapshot compare plus tick-timing compare
  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].cyc <= cyc) begin
      me = eq.pop_front();
      checks++;
      if (me.cyc != cyc || count !== me.cnt || busy !== me.busy ||
          done !== me.done || tick !== me.tick) begin
        errors++;
        $display("FAIL snap@%0d (now %0d): got count=%0d busy=%b done=%b tick=%b, want count=%0d busy=%b done=%b tick=%b",
                 me.cyc, cyc, count, busy, done, tick, me.cnt, me.busy, me.done, me.tick);
      end
    end
    if (tick === 1'b1) begin
      checks++;
      if (tq.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
      end else begin
        mt = tq.pop_front();
        if (mt != cyc) begin
          errors++;
          $display("FAIL tick_time: tick at cycle %0d, expected cycle %0d", cyc, mt);
        end
      end
    end
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc1();
  endtask

  task automatic snap(input int e, input logic [W-1:0] c, input logic b,
                      input logic d, input logic t);
    exp_t x;
    x.cyc = e; x.cnt = c; x.busy = b; x.done = d; x.tick = t;
    eq.push_back(x);
    if (t) tq.push_back(e);
  endtask

  // Closed-form expectation for a running (done=0) timer: j cycles after the
  // reference edge, the count has taken j/(pre+1) steps modulo (lim+1).
  task automatic model_run(input int base, input int j0, input int j1,
                           input int lim, input int pre);
    int   p;
    logic t;
    p = (lim + 1) * (pre + 1);
    for (int j = j0; j <= j1; j++) begin
      t = (j > 0) && (j % p == 0);
      snap(base + j, W'((j / (pre + 1)) % (lim + 1)), 1'b1, 1'b0, t);
    end
  endtask

  task automatic launch(input logic m, input logic [W-1:0] lim,
                        input logic [PW-1:0] pre, output int k);
    mode = m; limit = lim; prescale = pre; start = 1'b1;
    cyc1();
    start = 1'b0;
    k = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, k3;

    // Reset then idle
    cycn(2);
    snap(cyc, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int e = cyc + 1; e <= cyc + 10; e++) snap(e, '0, 1'b0, 1'b0, 1'b0);
    cycn(10);

    // One-shot limit 5, prescale 0; later input changes must be ignored
    launch(1'b0, 32'd5, 8'd0, k);
    limit = 32'd100; mode = 1'b1; prescale = 8'd3;
    for (int i = 0; i <= 5; i++) snap(k + i, W'(i), 1'b1, 1'b0, 1'b0);
    snap(k + 6, 32'd5, 1'b0, 1'b1, 1'b1);
    snap(k + 7, 32'd5, 1'b0, 1'b1, 1'b0);
    snap(k + 8, 32'd5, 1'b0, 1'b1, 1'b0);
    cycn(8);

    // Periodic limit 3, prescale 2 from DONE: 5 periods of 12
    launch(1'b1, 32'd3, 8'd2, k);
    model_run(k, 0, 60, 3, 2);
    cycn(60);

    // Pause for 7 cycles while count=2
    clear = 1'b1; snap(cyc + 1, '0, 1'b0, 1'b0, 1'b0); cyc1(); clear = 1'b0;
    launch(1'b1, 32'd3, 8'd2, k);
    model_run(k, 0, 6, 3, 2);
    cycn(6);
    stop = 1'b1;
    for (int e = k + 7; e <= k + 13; e++) snap(e, 32'd2, 1'b0, 1'b0, 1'b0);
    cycn(7);
    stop = 1'b0; start = 1'b1;
    model_run(k + 7, 7, 24, 3, 2);
    cyc1();
    start = 1'b0;
    cycn(17);

    // clear + stop + start together in RUN
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    snap(cyc + 1, '0, 1'b0, 1'b0, 1'b0);
    snap(cyc + 2, '0, 1'b0, 1'b0, 1'b0);
    cyc1();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    cyc1();

    // stop + start together in RUN -> PAUSE
    launch(1'b1, 32'd3, 8'd0, k);
    model_run(k, 0, 1, 3, 0);
    cyc1();
    stop = 1'b1; start = 1'b1;
    snap(k + 2, 32'd1, 1'b0, 1'b0, 1'b0);
    snap(k + 3, 32'd1, 1'b0, 1'b0, 1'b0);
    cycn(2);
    stop = 1'b0;
    snap(k + 4, 32'd2, 1'b1, 1'b0, 1'b0);
    cyc1();
    start = 1'b0;
    snap(k + 5, 32'd3, 1'b1, 1'b0, 1'b0);
    snap(k + 6, 32'd0, 1'b1, 1'b0, 1'b1);
    cycn(2);

    // Reset mid-RUN overrides start
    rst_n = 1'b0; start = 1'b1;
    snap(k + 7, '0, 1'b0, 1'b0, 1'b0);
    cyc1();
    rst_n = 1'b1; start = 1'b0;
    snap(k + 8, '0, 1'b0, 1'b0, 1'b0);
    cyc1();

    // One-shot to DONE, then relatch periodic with max limit
    launch(1'b0, 32'd2, 8'd0, k);
    snap(k, 32'd0, 1'b1, 1'b0, 1'b0);
    snap(k + 1, 32'd1, 1'b1, 1'b0, 1'b0);
    snap(k + 2, 32'd2, 1'b1, 1'b0, 1'b0);
    snap(k + 3, 32'd2, 1'b0, 1'b1, 1'b1);
    snap(k + 4, 32'd2, 1'b0, 1'b1, 1'b0);
    cycn(4);
    launch(1'b1, 32'hFFFF_FFFF, 8'd0, k2);
    for (int i = 0; i <= 5; i++) snap(k2 + i, W'(i), 1'b1, 1'b0, 1'b0);
    cycn(5);
    // start during RUN must not relatch limit=2
    limit = 32'd2; mode = 1'b0; start = 1'b1;
    snap(k2 + 6, 32'd6, 1'b1, 1'b0, 1'b0);
    cyc1();
    start = 1'b0;
    snap(k2 + 7, 32'd7, 1'b1, 1'b0, 1'b0);
    snap(k2 + 8, 32'd8, 1'b1, 1'b0, 1'b0);
    cycn(2);
    clear = 1'b1; snap(cyc + 1, '0, 1'b0, 1'b0, 1'b0); cyc1(); clear = 1'b0;
    launch(1'b1, 32'd2, 8'd0, k3);
    model_run(k3, 0, 6, 2, 0);
    cycn(6);

    // limit 0, prescale 0 periodic: tick every cycle after the first step
    clear = 1'b1; snap(cyc + 1, '0, 1'b0, 1'b0, 1'b0); cyc1(); clear = 1'b0;
    launch(1'b1, 32'd0, 8'd0, k);
    model_run(k, 0, 8, 0, 0);
    cycn(8);
    clear = 1'b1;
    snap(k + 9, '0, 1'b0, 1'b0, 1'b0);
    cyc1();
    clear = 1'b0;
    cycn(2);

    checks++;
    if (eq.size() != 0 || tq.size() != 0) begin
      errors++;
      $display("FAIL leftovers: %0d snapshots and %0d ticks never observed, want 0 and 0",
               eq.size(), tq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
